// File: rtl/id_ex_pkg.sv
// id_ex_pkg
//   Shared constants for the decode-to-execute operand stage:
//   - default datapath, register-index and control-bundle widths
//   - bit positions inside the decoded control bundle
//     (bit0 regWrite, bit1 memRead, bit2 memWrite, bit3 aluSrc, bits7:4 aluOp)
package id_ex_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CTRL_W_DEF = 8;

  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMREAD   = 1;
  localparam int CTRL_MEMWRITE  = 2;
  localparam int CTRL_ALUSRC    = 3;
  localparam int CTRL_ALUOP_LSB = 4;
  localparam int CTRL_ALUOP_W   = 4;

endpackage

// File: rtl/id_ex_operandos_bypass_operando.sv
// bypass_operando
//   Single-operand writeback bypass: when the writeback strobe is active and
//   its index matches the operand index, the writeback data replaces the base
//   value. Index 0 is treated like any other index.
//   Ports:
//     wbRegWrite, wbRD, wbDados : writeback strobe, index, data
//     indice                    : operand register index to compare
//     dadoBase                  : value used when there is no match
//     operando                  : selected operand
module bypass_operando #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              wbRegWrite,
  input  logic [ADDR_W-1:0] wbRD,
  input  logic [DATA_W-1:0] wbDados,
  input  logic [ADDR_W-1:0] indice,
  input  logic [DATA_W-1:0] dadoBase,
  output logic [DATA_W-1:0] operando
);

  assign operando = (wbRegWrite && (wbRD == indice)) ? wbDados : dadoBase;

endmodule

// File: rtl/id_ex_operandos.sv
// id_ex_operandos
//   Decode-to-execute pipeline register placed right after the register file.
//   Captures read data, immediate, indices and decoded control for one
//   instruction and offers it to execute through a valid/ready handshake.
//
//   Handshake: a transfer happens on a rising clock edge where the producer's
//   valid and the consumer's ready (pronto) are both 1. valid_ex never depends
//   combinationally on pronto_ex; pronto_id does depend on pronto_ex, flush,
//   valid_id and the source indices.
//
//   Ports:
//     clock, reset            : clock, asynchronous active-high reset
//     valid_id / pronto_id    : decode-side handshake
//     R1, R2, RD, imediato    : decoded indices and sign-extended immediate
//     ctrl_id                 : decoded control bundle
//     leituraR1, leituraR2    : register file read data
//     wbRegWrite, wbRD, wbDados : writeback port (bypass and snoop source)
//     flush                   : kill the instruction entering or held here
//     valid_ex / pronto_ex    : execute-side handshake
//     opA_ex, opB_ex, imediato_ex, R1_ex, R2_ex, RD_ex, ctrl_ex : slot contents
//
//   Optional build macro ID_EX_STATS_EN adds contador_bolhas (load-use
//   bubbles inserted) and contador_paradas (cycles held by execute back-pressure).
module id_ex_operandos
  import id_ex_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_id,
  output logic              pronto_id,
  input  logic [ADDR_W-1:0] R1,
  input  logic [ADDR_W-1:0] R2,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] imediato,
  input  logic [CTRL_W-1:0] ctrl_id,
  input  logic [DATA_W-1:0] leituraR1,
  input  logic [DATA_W-1:0] leituraR2,
  input  logic              wbRegWrite,
  input  logic [ADDR_W-1:0] wbRD,
  input  logic [DATA_W-1:0] wbDados,
  input  logic              flush,
  output logic              valid_ex,
  input  logic              pronto_ex,
  output logic [DATA_W-1:0] opA_ex,
  output logic [DATA_W-1:0] opB_ex,
  output logic [DATA_W-1:0] imediato_ex,
  output logic [ADDR_W-1:0] R1_ex,
  output logic [ADDR_W-1:0] R2_ex,
  output logic [ADDR_W-1:0] RD_ex,
  output logic [CTRL_W-1:0] ctrl_ex
`ifdef ID_EX_STATS_EN
  ,
  output logic [31:0]       contador_bolhas,
  output logic [31:0]       contador_paradas
`endif
);

  logic avanca;
  logic hazard;
  logic aceita;

  logic [DATA_W-1:0] capturaA;
  logic [DATA_W-1:0] capturaB;
  logic [DATA_W-1:0] snoopA;
  logic [DATA_W-1:0] snoopB;

  // Slot is free, or being drained this cycle.
  assign avanca = !valid_ex || pronto_ex;

  // Load-use: a load in the slot whose destination matches either incoming
  // source. Both sources are compared even if the instruction uses only one.
  assign hazard = valid_id && valid_ex && ctrl_ex[CTRL_MEMREAD] &&
                  ((RD_ex == R1) || (RD_ex == R2));

  assign pronto_id = avanca && !hazard && !flush;
  assign aceita    = valid_id && pronto_id;

  // Capture bypass: the register file writes on the same edge we capture,
  // so its read data is stale when the writeback targets our source.
  bypass_operando #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_capturaA (
    .wbRegWrite (wbRegWrite),
    .wbRD       (wbRD),
    .wbDados    (wbDados),
    .indice     (R1),
    .dadoBase   (leituraR1),
    .operando   (capturaA)
  );

  bypass_operando #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_capturaB (
    .wbRegWrite (wbRegWrite),
    .wbRD       (wbRD),
    .wbDados    (wbDados),
    .indice     (R2),
    .dadoBase   (leituraR2),
    .operando   (capturaB)
  );

  // Snoop: a held operand follows any writeback to its source register so it
  // is still current when execute finally takes it.
  bypass_operando #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_snoopA (
    .wbRegWrite (wbRegWrite),
    .wbRD       (wbRD),
    .wbDados    (wbDados),
    .indice     (R1_ex),
    .dadoBase   (opA_ex),
    .operando   (snoopA)
  );

  bypass_operando #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_snoopB (
    .wbRegWrite (wbRegWrite),
    .wbRD       (wbRD),
    .wbDados    (wbDados),
    .indice     (R2_ex),
    .dadoBase   (opB_ex),
    .operando   (snoopB)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_ex    <= 1'b0;
      opA_ex      <= '0;
      opB_ex      <= '0;
      imediato_ex <= '0;
      R1_ex       <= '0;
      R2_ex       <= '0;
      RD_ex       <= '0;
      ctrl_ex     <= '0;
    end else if (flush) begin
      // Data registers keep their contents; only liveness and control die.
      valid_ex <= 1'b0;
      ctrl_ex  <= '0;
    end else if (aceita) begin
      valid_ex    <= 1'b1;
      opA_ex      <= capturaA;
      opB_ex      <= capturaB;
      imediato_ex <= imediato;
      R1_ex       <= R1;
      R2_ex       <= R2;
      RD_ex       <= RD;
      ctrl_ex     <= ctrl_id;
    end else if (avanca) begin
      // Drained with nothing to replace it, or load-use bubble.
      valid_ex <= 1'b0;
      ctrl_ex  <= '0;
    end else if (valid_ex) begin
      opA_ex <= snoopA;
      opB_ex <= snoopB;
    end
  end

`ifdef ID_EX_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador_bolhas  <= '0;
      contador_paradas <= '0;
    end else begin
      if (hazard && pronto_ex) contador_bolhas <= contador_bolhas + 32'd1;
      if (valid_ex && !pronto_ex) contador_paradas <= contador_paradas + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_operandos.sv
module tb_id_ex_operandos;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CTRL_W = 8;
  localparam int EXP_W  = 3 * DATA_W + 3 * ADDR_W + CTRL_W;

  logic              clock;
  logic              reset;
  logic              valid_id;
  logic              pronto_id;
  logic [ADDR_W-1:0] R1, R2, RD;
  logic [DATA_W-1:0] imediato;
  logic [CTRL_W-1:0] ctrl_id;
  logic [DATA_W-1:0] leituraR1, leituraR2;
  logic              wbRegWrite;
  logic [ADDR_W-1:0] wbRD;
  logic [DATA_W-1:0] wbDados;
  logic              flush;
  logic              valid_ex;
  logic              pronto_ex;
  logic [DATA_W-1:0] opA_ex, opB_ex, imediato_ex;
  logic [ADDR_W-1:0] R1_ex, R2_ex, RD_ex;
  logic [CTRL_W-1:0] ctrl_ex;
`ifdef ID_EX_STATS_EN
  logic [31:0]       contador_bolhas;
  logic [31:0]       contador_paradas;
`endif

  int vetores;
  int erros;
  logic [EXP_W-1:0] exp_q[$];

  id_ex_operandos #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .valid_id    (valid_id),
    .pronto_id   (pronto_id),
    .R1          (R1),
    .R2          (R2),
    .RD          (RD),
    .imediato    (imediato),
    .ctrl_id     (ctrl_id),
    .leituraR1   (leituraR1),
    .leituraR2   (leituraR2),
    .wbRegWrite  (wbRegWrite),
    .wbRD        (wbRD),
    .wbDados     (wbDados),
    .flush       (flush),
    .valid_ex    (valid_ex),
    .pronto_ex   (pronto_ex),
    .opA_ex      (opA_ex),
    .opB_ex      (opB_ex),
    .imediato_ex (imediato_ex),
    .R1_ex       (R1_ex),
    .R2_ex       (R2_ex),
    .RD_ex       (RD_ex),
    .ctrl_ex     (ctrl_ex)
`ifdef ID_EX_STATS_EN
    ,
    .contador_bolhas  (contador_bolhas),
    .contador_paradas (contador_paradas)
`endif
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
    vetores++;
    if (atual !== esperado) begin
      erros++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  // Drivers
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                           input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] imm,
                           input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] l1,
                           input logic [DATA_W-1:0] l2);
    valid_id  = 1'b1;
    R1        = r1;
    R2        = r2;
    RD        = rd;
    imediato  = imm;
    ctrl_id   = c;
    leituraR1 = l1;
    leituraR2 = l2;
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [DATA_W-1:0] imm, input logic [ADDR_W-1:0] r1,
                          input logic [ADDR_W-1:0] r2, input logic [ADDR_W-1:0] rd,
                          input logic [CTRL_W-1:0] c);
    exp_q.push_back({a, b, imm, r1, r2, rd, c});
  endtask

  // Scoreboard monitor: pops one expectation per consumed slot.
  always @(negedge clock) begin
    if (!reset && valid_ex && pronto_ex) begin
      if (exp_q.size() == 0) begin
        check("saida_inesperada_valid_ex", {63'd0, valid_ex}, 64'd0);
      end else begin
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        check("sb_opA",     {32'd0, opA_ex},      {32'd0, e[EXP_W-1 -: DATA_W]});
        check("sb_opB",     {32'd0, opB_ex},      {32'd0, e[EXP_W-1-DATA_W -: DATA_W]});
        check("sb_imediato",{32'd0, imediato_ex}, {32'd0, e[EXP_W-1-2*DATA_W -: DATA_W]});
        check("sb_indices_ctrl", {41'd0, R1_ex, R2_ex, RD_ex, ctrl_ex},
              {41'd0, e[3*ADDR_W+CTRL_W-1:0]});
      end
    end
  end

  initial begin
    reset = 1'b1; valid_id = 1'b0; R1 = '0; R2 = '0; RD = '0; imediato = '0;
    ctrl_id = '0; leituraR1 = '0; leituraR2 = '0; wbRegWrite = 1'b0; wbRD = '0;
    wbDados = '0; flush = 1'b0; pronto_ex = 1'b0;
    vetores = 0; erros = 0;

    repeat (2) @(posedge clock);
    #1;
    check("reset_valid_ex", {63'd0, valid_ex}, 64'd0);
    check("reset_ctrl_ex",  {56'd0, ctrl_ex}, 64'd0);
    check("reset_opA",      {32'd0, opA_ex}, 64'd0);
    check("reset_opB",      {32'd0, opB_ex}, 64'd0);
    check("reset_imediato", {32'd0, imediato_ex}, 64'd0);
    check("reset_RD_ex",    {59'd0, RD_ex}, 64'd0);
    check("reset_pronto_id",{63'd0, pronto_id}, 64'd1);
    reset = 1'b0;
    step();

    // Same-cycle writeback bypass on R1
    set_instr(5'd5, 5'd6, 5'd9, 32'h100, 8'h31, 32'h11, 32'h22);
    wbRegWrite = 1'b1; wbRD = 5'd5; wbDados = 32'hDEAD; pronto_ex = 1'b1;
    #1;
    check("pronto_id_livre", {63'd0, pronto_id}, 64'd1);
    push_exp(32'hDEAD, 32'h22, 32'h100, 5'd5, 5'd6, 5'd9, 8'h31);
    step();
    check("latencia_1", {63'd0, valid_ex}, 64'd1);

    // Back-to-back accepts
    wbRegWrite = 1'b0;
    set_instr(5'd1, 5'd2, 5'd4, 32'h5, 8'h08, 32'hA, 32'hB);
    push_exp(32'hA, 32'hB, 32'h5, 5'd1, 5'd2, 5'd4, 8'h08);
    step();
    check("sem_lacuna_1", {63'd0, valid_ex}, 64'd1);
    set_instr(5'd3, 5'd4, 5'd3, 32'h40, 8'h03, 32'hC, 32'hD);
    push_exp(32'hC, 32'hD, 32'h40, 5'd3, 5'd4, 5'd3, 8'h03);
    step();
    check("sem_lacuna_2", {63'd0, valid_ex}, 64'd1);

    // Load-use on R1 with the load being consumed
    set_instr(5'd3, 5'd7, 5'd10, 32'h77, 8'h01, 32'h33, 32'h44);
    #1;
    check("load_use_pronto_id", {63'd0, pronto_id}, 64'd0);
    push_exp(32'h33, 32'h1234, 32'h77, 5'd3, 5'd7, 5'd10, 8'h01);
    step();
    check("bolha_valid_ex", {63'd0, valid_ex}, 64'd0);
    check("bolha_ctrl_ex",  {56'd0, ctrl_ex}, 64'd0);
    check("pos_bolha_pronto_id", {63'd0, pronto_id}, 64'd1);
    step();
    check("aceito_pos_bolha", {63'd0, valid_ex}, 64'd1);

    // Stall snoop on R2_ex=7
    valid_id = 1'b0; pronto_ex = 1'b0;
    wbRegWrite = 1'b1; wbRD = 5'd7; wbDados = 32'h1234;
    step();
    check("snoop_valid_ex", {63'd0, valid_ex}, 64'd1);
    check("snoop_opB", {32'd0, opB_ex}, {32'd0, 32'h1234});
    check("snoop_opA_mantido", {32'd0, opA_ex}, {32'd0, 32'h33});
    wbRegWrite = 1'b0;
    step();
    step();
    check("parada_mantem", {63'd0, valid_ex}, 64'd1);
`ifdef ID_EX_STATS_EN
    check("contador_paradas", {32'd0, contador_paradas}, 64'd3);
    check("contador_bolhas",  {32'd0, contador_bolhas}, 64'd1);
`endif
    pronto_ex = 1'b1;
    step();
    check("drenado", {63'd0, valid_ex}, 64'd0);

    // Flush with a load-use hazard present (held load is killed)
    set_instr(5'd1, 5'd2, 5'd12, 32'h5, 8'h03, 32'h1, 32'h2);
    step();
    pronto_ex = 1'b0;
    set_instr(5'd12, 5'd4, 5'd13, 32'h0, 8'h01, 32'h0, 32'h0);
    flush = 1'b1;
    #1;
    check("flush_pronto_id", {63'd0, pronto_id}, 64'd0);
    step();
    flush = 1'b0;
    check("flush_valid_ex", {63'd0, valid_ex}, 64'd0);
    check("flush_ctrl_ex",  {56'd0, ctrl_ex}, 64'd0);
    check("flush_dados_mantidos", {59'd0, RD_ex}, 64'd12);

    // Asynchronous reset while stalled with a live slot
    step();
    valid_id = 1'b0;
    check("pre_reset_valid", {63'd0, valid_ex}, 64'd1);
    step();
    #2;
    reset = 1'b1;
    #1;
    check("reset_async_valid", {63'd0, valid_ex}, 64'd0);
    check("reset_async_ctrl",  {56'd0, ctrl_ex}, 64'd0);
    check("reset_async_opA",   {32'd0, opA_ex}, 64'd0);
    check("reset_async_RD",    {59'd0, RD_ex}, 64'd0);
    step();
    reset = 1'b0;
    step();

    check("fila_vazia", {32'd0, exp_q.size()}, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
